// File: rtl/dmem_responder.sv
// Handshaked RV32I data memory: one load/store in flight, fixed WAIT_STATES latency, byte-lane stores.
// Define DMEM_ERR_TRAP_EN to report misaligned/illegal/out-of-range accesses on rsp_err.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic [3:0]              cnt_q;

    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

    logic                    src_we;
    logic [ADDR_WIDTH-1:0]   src_addr;
    logic [DATA_WIDTH-1:0]   src_wdata;
    logic [1:0]              src_size;
    logic                    src_unsigned;

    logic [ADDR_WIDTH-3:0]   idx;
    logic [IDX_W-1:0]        word_sel;
    logic [1:0]              off;
    logic                    acc_err;
    logic [3:0]              wmask;
    logic [DATA_WIDTH-1:0]   wdata_lane;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_shift;
    logic [DATA_WIDTH-1:0]   ld_data;
    logic                    access_now;
    logic                    mem_we;

    // With zero wait states the access happens on the accept edge, straight from the request inputs.
    always_comb begin
        if (state_q == IDLE) begin
            src_we       = req_we;
            src_addr     = req_addr;
            src_wdata    = req_wdata;
            src_size     = req_size;
            src_unsigned = req_unsigned;
        end else begin
            src_we       = we_q;
            src_addr     = addr_q;
            src_wdata    = wdata_q;
            src_size     = size_q;
            src_unsigned = unsigned_q;
        end
    end

    assign idx = src_addr[ADDR_WIDTH-1:2];

`ifdef DMEM_ERR_TRAP_EN
    always_comb begin
        word_sel = idx[IDX_W-1:0];
        off      = src_addr[1:0];
        acc_err  = 1'b0;
        case (src_size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = src_addr[0];
            2'b10:   acc_err = (src_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
        if (idx >= (ADDR_WIDTH-2)'(DEPTH_WORDS)) begin
            acc_err = 1'b1;
        end
    end
`else
    always_comb begin
        word_sel = IDX_W'(idx % (ADDR_WIDTH-2)'(DEPTH_WORDS));
        acc_err  = 1'b0;
        case (src_size)
            2'b00:   off = src_addr[1:0];
            2'b01:   off = {src_addr[1], 1'b0};
            default: off = 2'b00;
        endcase
    end
`endif

    always_comb begin
        wmask      = 4'b1111;
        wdata_lane = src_wdata;
        case (src_size)
            2'b00: begin
                wmask      = 4'b0001 << off;
                wdata_lane = {4{src_wdata[7:0]}};
            end
            2'b01: begin
                wmask      = 4'b0011 << off;
                wdata_lane = {2{src_wdata[15:0]}};
            end
            default: begin
                wmask      = 4'b1111;
                wdata_lane = src_wdata;
            end
        endcase
    end

    always_comb begin
        rd_word  = mem_q[word_sel];
        rd_shift = rd_word >> {off, 3'b000};
        ld_data  = '0;
        if (!src_we && !acc_err) begin
            case (src_size)
                2'b00:   ld_data = src_unsigned ? {24'd0, rd_shift[7:0]}
                                                : {{24{rd_shift[7]}}, rd_shift[7:0]};
                2'b01:   ld_data = src_unsigned ? {16'd0, rd_shift[15:0]}
                                                : {{16{rd_shift[15]}}, rd_shift[15:0]};
                default: ld_data = rd_word;
            endcase
        end
    end

    always_comb begin
        access_now = 1'b0;
        if (state_q == IDLE) begin
            access_now = req_valid && (WAIT_STATES == 0);
        end else if (state_q == WAIT) begin
            access_now = (cnt_q == 4'd0);
        end
    end

    assign mem_we = rst_n && access_now && src_we && !acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem_q[word_sel][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        size_q      <= req_size;
                        unsigned_q  <= req_unsigned;
                        req_ready_q <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= ld_data;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data;
                        rsp_err_q   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_STATES=3); error expectations follow DMEM_ERR_TRAP_EN.
module tb_dmem_responder;

    localparam int unsigned WS = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        e;

    dmem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH_WORDS(1024),
        .WAIT_STATES(WS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction; hold > 0 keeps rsp_ready low that many cycles after rsp_valid appears.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int hold,
                        output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        rsp_ready    = (hold == 0);
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_addr     = ~addr;
        req_wdata    = ~wdata;
        req_size     = ~size;
        req_unsigned = ~uns;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rsp_latency", 32'(n), 32'(WS + 1));
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, rdata);
            check("hold_err", 32'(rsp_err), 32'(err));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rsp_cleared", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd, e);
        check("sw_rdata", rd, 32'd0);
        check("sw_err", 32'(e), 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, e);
        check("lw_10", rd, 32'hDEADBEEF);
        check("lw_10_err", 32'(e), 32'd0);

        xfer(1'b1, 32'h13, 32'h80, 2'b00, 1'b0, 0, rd, e);
        xfer(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, rd, e);
        check("lb_13", rd, 32'hFFFFFF80);
        xfer(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, rd, e);
        check("lbu_13", rd, 32'h00000080);
        xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, e);
        check("lw_after_sb", rd, 32'h80ADBEEF);

        xfer(1'b1, 32'h12, 32'h1234, 2'b01, 1'b0, 0, rd, e);
        xfer(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 0, rd, e);
        check("lh_12", rd, 32'h00001234);
        xfer(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 0, rd, e);
        check("lh_10", rd, 32'hFFFFBEEF);
        xfer(1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 0, rd, e);
        check("lhu_10", rd, 32'h0000BEEF);
        xfer(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 0, rd, e);
`ifdef DMEM_ERR_TRAP_EN
        check("lh_11_err", 32'(e), 32'd1);
        check("lh_11_rdata", rd, 32'd0);
`else
        check("lh_11_err", 32'(e), 32'd0);
        check("lh_11_rdata", rd, 32'hFFFFBEEF);
`endif
        xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, rd, e);
        check("lw_after_sh", rd, 32'h1234BEEF);

        xfer(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, rd, e);
        check("lw_held", rd, 32'h1234BEEF);

        xfer(1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, 0, rd, e);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h22222222;
        req_size  = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rdata", rsp_rdata, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_quiet", 32'(rsp_valid), 32'd0);
        xfer(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, rd, e);
        check("lw_20_old", rd, 32'h11111111);

        xfer(1'b1, 32'h0, 32'hCAFEF00D, 2'b10, 1'b0, 0, rd, e);
        xfer(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 0, rd, e);
`ifdef DMEM_ERR_TRAP_EN
        check("lw_oor_err", 32'(e), 32'd1);
        check("lw_oor_rdata", rd, 32'd0);
`else
        check("lw_oor_err", 32'(e), 32'd0);
        check("lw_oor_rdata", rd, 32'hCAFEF00D);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
